// File: rtl/event_record_types.sv
// Shared event record layout and serializer constants.
// Fields are packed MSB-first, so the 32-bit reserved field lands in word 0.
package event_record_types;

  localparam int EVENT_RECORD_BITS = 256;
  localparam int EVENT_WORDS       = 8;
  localparam int EVENT_PAD_LSB     = 225;

  typedef struct packed {
    logic [63:0] ts_ns;
    logic [63:0] update_id;
    logic        side_bit;
    logic [31:0] price_q32;
    logic [31:0] qty_q32;
    logic [31:0] reserved;
  } event_record_t;

  // Bit position of update_id inside the zero-extended record (ts_ns and update_id sit on top).
  localparam int UID_LSB = $bits(event_record_t) - 128;

  localparam logic [EVENT_RECORD_BITS-1:0] PAD_MASK =
    {{(EVENT_RECORD_BITS-EVENT_PAD_LSB){1'b0}}, {EVENT_PAD_LSB{1'b1}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  function automatic logic [31:0] record_word(input logic [EVENT_RECORD_BITS-1:0] rec,
                                              input logic [2:0] k);
    return rec[{k, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/event_record_serializer.sv
// Serializes 256-bit event records into eight 32-bit AXI-Stream words, LSB word first,
// with an active/pending double buffer so back-to-back records stream without bubbles.
module event_record_serializer
  import event_record_types::*;
#(
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [255:0] s_record,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [31:0]  rec_count,
  output logic [31:0]  gap_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the source
  // holds data stable while valid is high and ready is low.

  ser_state_t                   state;
  logic [EVENT_RECORD_BITS-1:0] active_q;
  logic [EVENT_RECORD_BITS-1:0] pending_q;
  logic                         pending_valid;
  logic [2:0]                   beat;
  logic [63:0]                  last_uid;
  logic                         first_rec;

  logic                         in_fire;
  logic                         out_fire;
  logic                         last_fire;
  logic [EVENT_RECORD_BITS-1:0] in_masked;
  logic [63:0]                  in_uid;

  assign s_ready   = !pending_valid;
  assign in_fire   = s_valid && s_ready;
  assign out_fire  = m_axis_tvalid && m_axis_tready;
  assign last_fire = out_fire && (beat == 3'd7);
  assign in_masked = s_record & PAD_MASK;
  assign in_uid    = s_record[UID_LSB +: 64];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      active_q      <= '0;
      pending_q     <= '0;
      pending_valid <= 1'b0;
      beat          <= 3'd0;
      last_uid      <= '0;
      first_rec     <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      rec_count     <= '0;
      gap_count     <= '0;
    end else begin
      // Sequence tracking looks only at accepted records, independent of the send path.
      if (in_fire) begin
        first_rec <= 1'b0;
        last_uid  <= in_uid;
        if (CHECK_SEQ && !first_rec && (in_uid != last_uid + 64'd1))
          gap_count <= gap_count + 32'd1;
      end

      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            state         <= ST_SEND;
            active_q      <= in_masked;
            beat          <= 3'd0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= record_word(in_masked, 3'd0);
            m_axis_tlast  <= 1'b0;
          end
        end

        ST_SEND: begin
          // An accept while the active slot is still busy parks the record in pending.
          if (in_fire && !last_fire) begin
            pending_q     <= in_masked;
            pending_valid <= 1'b1;
          end
          if (out_fire) begin
            if (beat != 3'd7) begin
              beat         <= beat + 3'd1;
              m_axis_tdata <= record_word(active_q, beat + 3'd1);
              m_axis_tlast <= (beat == 3'd6);
            end else begin
              rec_count    <= rec_count + 32'd1;
              beat         <= 3'd0;
              m_axis_tlast <= 1'b0;
              if (pending_valid) begin
                active_q      <= pending_q;
                pending_valid <= 1'b0;
                m_axis_tdata  <= record_word(pending_q, 3'd0);
              end else if (in_fire) begin
                active_q     <= in_masked;
                m_axis_tdata <= record_word(in_masked, 3'd0);
              end else begin
                state         <= ST_IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/event_record_serializer.md
EVENT_RECORD_SERIALIZER -- requirements
Module: event_record_serializer

Interface
REQ-001 SHALL have parameter CHECK_SEQ, default 1: 1 enables update_id gap counting; 0 holds gap_count at 0.
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_valid  input  1  record-in valid.
REQ-005 SHALL have port s_ready  output  1  record-in ready.
REQ-006 SHALL have port s_record  input  256  event_record_t zero-extended to 256 bits.
REQ-007 SHALL have port m_axis_tdata  output  32  serialized word.
REQ-008 SHALL have port m_axis_tvalid  output  1  word valid.
REQ-009 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-010 SHALL have port m_axis_tlast  output  1  high on the 8th word of each record.
REQ-011 SHALL have port rec_count  output  32  records fully sent (tlast handshakes).
REQ-012 SHALL have port gap_count  output  32  accepted records whose update_id != previous accepted update_id + 1.

Function
REQ-013 Input handshake SHALL be s_valid && s_ready on a rising edge; output handshake SHALL be m_axis_tvalid && m_axis_tready.
REQ-014 Storage SHALL be two 256-bit slots: active (being sent) and pending; s_ready = !pending_valid.
REQ-015 Accepted record SHALL go to active if active empty or freed that same cycle; otherwise to pending.
REQ-016 Word k (k=0..7) SHALL be active[32k+31:32k], LSB word first; bits [255:225] SHALL be sent as zero regardless of input.
REQ-017 Latency: a record accepted at edge N into an empty block SHALL present word 0 with tvalid=1 after edge N; no combinational s_valid->tvalid path.
REQ-018 FSM states IDLE (active empty) and SEND; IDLE->SEND on accept; SEND->IDLE on word-7 handshake with pending empty and no simultaneous accept; SEND->SEND on word-7 handshake when pending valid (pending moves to active, word 0 next cycle) or a same-cycle accept.
REQ-019 With tready held high and records always available, output SHALL be gapless: one word per cycle, tlast every 8th cycle.
REQ-020 Beat counter SHALL be 3 bits, advance only on output handshake, wrap 7->0 on tlast.
REQ-021 tdata/tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-022 rec_count SHALL increment on each tlast handshake, wrapping 0xFFFFFFFF->0.
REQ-023 gap_count SHALL be evaluated on input accept against the last accepted update_id (64-bit, +1 modulo 2^64); the first record after reset SHALL NOT be counted; wraps at 2^32.
REQ-024 side_bit, price_q32, qty_q32, reserved SHALL be passed unaltered.

Reset
REQ-025 On rst: s_ready=1 (deasserts only when pending full), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, rec_count=0, gap_count=0, FSM=IDLE, beat=0, both slots invalid, first-record flag set.
REQ-026 Reset mid-record SHALL discard active and pending records with no tlast emitted; the next record after reset starts at word 0.

Structure
REQ-027 event_record_t, EVENT_RECORD_BITS=256, EVENT_WORDS=8, and EVENT_PAD_LSB=225 SHALL live in package event_record_types; the module SHALL import them, with no local copies.
REQ-028 Single module, no sub-modules; double buffer and FSM inline.

Verification
REQ-029 Single record ts_ns=0x1122334455667788, update_id=5, side=1, price=0x00010000, qty=0x00000200, reserved=0xDEADBEEF, tready=1 -> word0=0xDEADBEEF, word1=0x00000200, word2=0x00010000, tlast only on word7, rec_count=1.
REQ-030 Three back-to-back records, tready=1 -> 24 consecutive tvalid cycles, tlast at cycles 8/16/24, s_ready low only while pending full.
REQ-031 tready toggles 1,0,0,1 pattern across a record -> tdata stable during stalls, exactly 8 words, word order intact.
REQ-032 update_ids 10,11,13,14 -> gap_count=1; with CHECK_SEQ=0 -> gap_count=0; first record after reset with update_id 100 -> no gap counted.
REQ-033 Input bits [255:225] driven all-ones -> word7 bits [31:1] = 0 (bit 0 = ts_ns[63]).
REQ-034 rst asserted at word 3 of record with pending full -> next cycle tvalid=0, s_ready=1, counters 0; following record emits word 0 first.
